// File: rtl/memory_stage.sv
// memory_stage: accepts executor ops, forwards pass-through results to
// writeback one cycle later, and runs LOAD/STORE through a request/ack
// data-memory handshake with registered writeback.
// Optional build macro MEMORY_STAGE_TIMEOUT_EN adds an 8-bit wait-cycle
// counter that aborts a stalled memory op and sets the sticky mem_fault.
module memory_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        x_valid,
  input  logic [3:0]  x_op,
  input  logic [2:0]  x_dest,
  input  logic [15:0] x_addr,
  input  logic [15:0] x_store_data,
  input  logic [15:0] x_reg_value,
  input  logic        x_reg_write_enable,
  output logic        x_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [2:0]  wb_dest,
  output logic [15:0] wb_value,
  output logic        wb_write_enable,
  output logic        mem_fault
);

  localparam logic [3:0] OP_LOAD  = 4'h6;
  localparam logic [3:0] OP_STORE = 4'h7;
  localparam logic [2:0] DEST_SINK = 3'd7;

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t     state, state_next;
  logic       is_mem_op;
  logic       ack_seen;
  logic       timeout;
  logic [2:0] lat_dest;

  assign is_mem_op = (x_op == OP_LOAD) || (x_op == OP_STORE);
  assign ack_seen  = (state == WAIT_ACK) && dmem_req && dmem_ack;

`ifdef MEMORY_STAGE_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Abort fires on the edge where the no-ack count would reach 255,
  // i.e. at the end of the 255th WAIT_ACK cycle without an ack.
  assign timeout = (state == WAIT_ACK) && !dmem_ack && (wait_cnt == 8'd254);

  // Wait-cycle counter and sticky fault flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
    end else begin
      if (state == IDLE && x_valid && is_mem_op)
        wait_cnt <= '0;
      else if (state == WAIT_ACK && !dmem_ack)
        wait_cnt <= wait_cnt + 8'd1;
      if (timeout)
        mem_fault <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign mem_fault = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (x_valid && is_mem_op) state_next = WAIT_ACK;
      WAIT_ACK: if (ack_seen || timeout)  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    x_ready = (state == IDLE);
  end

  // Memory request and writeback registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_wdata      <= '0;
      wb_valid        <= 1'b0;
      wb_dest         <= '0;
      wb_value        <= '0;
      wb_write_enable <= 1'b0;
      lat_dest        <= '0;
    end else begin
      wb_valid        <= 1'b0;
      wb_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (x_valid) begin
            if (is_mem_op) begin
              dmem_req   <= 1'b1;
              dmem_we    <= (x_op == OP_STORE);
              dmem_addr  <= x_addr;
              dmem_wdata <= x_store_data;
              lat_dest   <= x_dest;
            end else begin
              wb_valid        <= 1'b1;
              wb_dest         <= x_dest;
              wb_value        <= x_reg_value;
              wb_write_enable <= x_reg_write_enable && (x_dest != DEST_SINK);
            end
          end
        end
        WAIT_ACK: begin
          if (ack_seen) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wb_valid <= 1'b1;
            wb_dest  <= lat_dest;
            if (dmem_we) begin
              wb_value <= '0;
            end else begin
              wb_value        <= dmem_rdata;
              wb_write_enable <= (lat_dest != DEST_SINK);
            end
          end else if (timeout) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wb_valid <= 1'b1;
            wb_dest  <= lat_dest;
            wb_value <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 clk  in  1  rising-edge clock; all state changes on posedge clk.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 x_valid  in  1  executor presents an op this cycle.
REQ-004 x_op  in  4  op code; LOAD=4'h6, STORE=4'h7, any other value is a pass-through op.
REQ-005 x_dest  in  3  destination register.
REQ-006 x_addr  in  16  memory word address (LOAD/STORE).
REQ-007 x_store_data  in  16  STORE write data.
REQ-008 x_reg_value / x_reg_write_enable  in  16 / 1  executor result and write enable for pass-through ops.
REQ-009 x_ready  out  1  stage accepts an op this cycle; executor holds its op while 0.
REQ-010 dmem_req / dmem_we  out  1 / 1  data-memory request and write strobe.
REQ-011 dmem_addr / dmem_wdata  out  16 / 16  request address and write data.
REQ-012 dmem_rdata / dmem_ack  in  16 / 1  read data and completion; both valid only in a cycle where dmem_req=1.
REQ-013 wb_valid / wb_dest / wb_value / wb_write_enable  out  1 / 3 / 16 / 1  registered writeback to the register file.
REQ-014 mem_fault  out  1  sticky timeout flag (see Configuration).

Function
REQ-015 FSM states: IDLE, WAIT_ACK; x_ready=1 only in IDLE.
REQ-016 IDLE, x_valid=1, op not LOAD/STORE: next cycle wb_valid=1, wb_dest=x_dest, wb_value=x_reg_value, wb_write_enable=x_reg_write_enable (1-cycle latency).
REQ-017 IDLE, x_valid=1, op LOAD/STORE: latch op/dest/addr/data, go to WAIT_ACK; next cycle dmem_req=1, dmem_we=1 for STORE and 0 for LOAD; wb_valid=0.
REQ-018 In WAIT_ACK, dmem_req, dmem_we, dmem_addr and dmem_wdata stay constant until the edge at which dmem_ack=1 is sampled.
REQ-019 On sampled ack: dmem_req=0 next cycle, state returns to IDLE; LOAD gives wb_valid=1, wb_value=dmem_rdata, wb_write_enable=1; STORE gives wb_valid=1, wb_write_enable=0, wb_value=0.
REQ-020 Minimum memory-op latency is acceptance edge to wb_valid in 2 cycles (ack in first request cycle); each extra wait cycle adds 1.
REQ-021 wb_valid is a 1-cycle pulse per accepted op; with x_valid=0 in IDLE, wb_valid=0 and wb_write_enable=0.
REQ-022 x_dest=7: op executes normally (LOAD still reads memory) but wb_write_enable is forced 0.
REQ-023 dmem_ack while dmem_req=0 is ignored.
REQ-024 Back-to-back: an op presented in the cycle the FSM returns to IDLE is accepted that cycle; no bubble beyond REQ-015.
REQ-025 Address and data are 16-bit, unmodified; no alignment or range checks.

Reset
REQ-026 reset=1: next edge state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_dest=0, wb_value=0, wb_write_enable=0, mem_fault=0, timeout counter=0.
REQ-027 Reset during WAIT_ACK abandons the transaction; no writeback; an ack arriving afterward is ignored.
REQ-028 reset overrides x_valid and dmem_ack in the same cycle.

Configuration
REQ-029 Macro MEMORY_STAGE_TIMEOUT_EN: when defined, an 8-bit counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle without ack; at 255 with no ack, drop dmem_req, return to IDLE, set mem_fault=1 (sticky until reset), and emit wb_valid=1 with wb_write_enable=0.
REQ-030 Undefined: no counter, WAIT_ACK persists until ack, and mem_fault is constant 0.

Verification
REQ-031 Pass-through: ADD op, dest=3, value=16'h1234, we=1 -> next cycle wb_valid=1, wb_dest=3, wb_value=16'h1234, wb_write_enable=1.
REQ-032 LOAD addr=16'h0040, ack on the 3rd request cycle, rdata=16'hBEEF -> dmem_req high 3 cycles, addr stable, x_ready=0 during that time, then wb_value=16'hBEEF, wb_write_enable=1.
REQ-033 STORE addr=16'h0010, data=16'h00AA, immediate ack -> dmem_we=1, wdata=16'h00AA, wb_valid=1, wb_write_enable=0; a following LOAD is accepted in the return-to-IDLE cycle.
REQ-034 Reset asserted in 2nd WAIT_ACK cycle, ack 1 cycle later -> dmem_req=0 after the reset edge, no wb_valid, ack ignored.
REQ-035 TIMEOUT_EN defined, LOAD with no ack -> after 255 wait cycles mem_fault=1, wb_valid pulse with wb_write_enable=0, x_ready=1; mem_fault clears only on reset.
